// File: rtl/change_dispenser.sv
// ============================================================================
//  Module   : change_dispenser
//  Purpose  : Greedy three-tube coin-change dispenser with timed solenoid
//             pulses, settling gaps and saturating tube inventory.
//             Optional macro CHANGE_DISPENSER_COUNT_EN adds coins_dispensed.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser #(
  parameter int COIN_A_VALUE = 5,
  parameter int COIN_B_VALUE = 2,
  parameter int COIN_C_VALUE = 1,
  parameter int PULSE_CYCLES = 5000000,
  parameter int GAP_CYCLES   = 5000000,
  parameter int TUBE_INIT    = 10,
  parameter int TUBE_MAX     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       refill_pulse,
  input  logic [1:0] refill_sel,
  output logic       eject_a,
  output logic       eject_b,
  output logic       eject_c,
  output logic       busy,
  output logic       done,
  output logic       short_flag,
  output logic [7:0] remaining,
  output logic [7:0] tube_a,
  output logic [7:0] tube_b,
  output logic [7:0] tube_c
`ifdef CHANGE_DISPENSER_COUNT_EN
  ,
  output logic [15:0] coins_dispensed
`endif
);

  localparam logic [7:0]  c_val_a      = 8'(COIN_A_VALUE);
  localparam logic [7:0]  c_val_b      = 8'(COIN_B_VALUE);
  localparam logic [7:0]  c_val_c      = 8'(COIN_C_VALUE);
  localparam logic [7:0]  c_tube_init  = 8'(TUBE_INIT);
  localparam logic [7:0]  c_tube_max   = 8'(TUBE_MAX);
  localparam logic [31:0] c_pulse_last = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] c_gap_last   = 32'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_EJECT  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state, w_next_state;
  logic [31:0] r_timer, w_next_timer;
  logic [2:0]  r_eject, w_next_eject;      // one-hot {a, b, c}
  logic [7:0]  r_remaining, w_next_remaining;
  logic        r_short, w_next_short;
  logic [7:0]  r_tube_a, r_tube_b, r_tube_c;
  logic [2:0]  w_pick, w_dec, w_inc;
  logic [7:0]  w_pick_val;

  // Simultaneous refill and dispense on one tube cancel out.
  function automatic logic [7:0] tube_next(input logic [7:0] cur, input logic inc,
                                           input logic dec);
    logic [7:0] nxt;
    nxt = cur;
    if (inc && !dec && cur < c_tube_max) nxt = cur + 8'd1;
    else if (dec && !inc && cur != 8'd0) nxt = cur - 8'd1;
    return nxt;
  endfunction

  always_comb begin
    w_pick     = 3'b000;
    w_pick_val = 8'd0;
    if (r_tube_a != 8'd0 && c_val_a <= r_remaining) begin
      w_pick     = 3'b100;
      w_pick_val = c_val_a;
    end else if (r_tube_b != 8'd0 && c_val_b <= r_remaining) begin
      w_pick     = 3'b010;
      w_pick_val = c_val_b;
    end else if (r_tube_c != 8'd0 && c_val_c <= r_remaining) begin
      w_pick     = 3'b001;
      w_pick_val = c_val_c;
    end
  end

  always_comb begin
    w_inc = 3'b000;
    if (refill_pulse) begin
      case (refill_sel)
        2'd0:    w_inc = 3'b100;
        2'd1:    w_inc = 3'b010;
        2'd2:    w_inc = 3'b001;
        default: w_inc = 3'b000;
      endcase
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_timer     = r_timer;
    w_next_eject     = r_eject;
    w_next_remaining = r_remaining;
    w_next_short     = r_short;
    w_dec            = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_remaining = amount;
          w_next_short     = 1'b0;
          w_next_state     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (r_remaining == 8'd0) begin
          w_next_state = S_DONE;
        end else if (w_pick != 3'b000) begin
          w_dec            = w_pick;
          w_next_remaining = r_remaining - w_pick_val;
          w_next_eject     = w_pick;
          w_next_timer     = c_pulse_last;
          w_next_state     = S_EJECT;
        end else begin
          w_next_short = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_EJECT: begin
        if (r_timer == 32'd0) begin
          w_next_eject = 3'b000;
          w_next_timer = c_gap_last;
          w_next_state = S_GAP;
        end else begin
          w_next_timer = r_timer - 32'd1;
        end
      end
      S_GAP: begin
        if (r_timer == 32'd0) w_next_state = S_SELECT;
        else                  w_next_timer = r_timer - 32'd1;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_timer     <= 32'd0;
      r_eject     <= 3'b000;
      r_remaining <= 8'd0;
      r_short     <= 1'b0;
      r_tube_a    <= c_tube_init;
      r_tube_b    <= c_tube_init;
      r_tube_c    <= c_tube_init;
    end else begin
      r_state     <= w_next_state;
      r_timer     <= w_next_timer;
      r_eject     <= w_next_eject;
      r_remaining <= w_next_remaining;
      r_short     <= w_next_short;
      r_tube_a    <= tube_next(r_tube_a, w_inc[2], w_dec[2]);
      r_tube_b    <= tube_next(r_tube_b, w_inc[1], w_dec[1]);
      r_tube_c    <= tube_next(r_tube_c, w_inc[0], w_dec[0]);
    end
  end

  assign eject_a    = r_eject[2];
  assign eject_b    = r_eject[1];
  assign eject_c    = r_eject[0];
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign short_flag = r_short;
  assign remaining  = r_remaining;
  assign tube_a     = r_tube_a;
  assign tube_b     = r_tube_b;
  assign tube_c     = r_tube_c;

`ifdef CHANGE_DISPENSER_COUNT_EN
  logic [15:0] r_coin_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_coin_count <= 16'd0;
    end else if (r_state == S_SELECT && w_next_state == S_EJECT &&
                 r_coin_count != 16'hFFFF) begin
      r_coin_count <= r_coin_count + 16'd1;
    end
  end

  assign coins_dispensed = r_coin_count;
`endif

endmodule

`default_nettype wire
